// File: rtl/tank_key_sched_if.sv
// rtl/tank_key_sched_if.sv - key input and per-player command bundle for tank_key_sched
interface tank_key_sched_if;
    logic [7:0] ascii;
    logic       press;
    logic [1:0] p1_dir;
    logic       p1_move;
    logic       p1_fire;
    logic [1:0] p2_dir;
    logic       p2_move;
    logic       p2_fire;
    logic       paused;

    modport master (
        output ascii, press,
        input  p1_dir, p1_move, p1_fire, p2_dir, p2_move, p2_fire, paused
    );

    modport slave (
        input  ascii, press,
        output p1_dir, p1_move, p1_fire, p2_dir, p2_move, p2_fire, paused
    );
endinterface

// File: rtl/tank_key_sched.sv
// rtl/tank_key_sched.sv - tank keyboard scheduler: per-player dir/move/fire and pause; TANK_AUTOFIRE_EN enables held-key autofire
module tank_key_sched #(
    parameter int unsigned MOVE_DIV = 2_000_000,
    parameter int unsigned FIRE_CD  = 50_000_000
) (
    input  logic             clk_100mhz,
    input  logic             rst,
    tank_key_sched_if.slave  kb
);
    // Direction keys have bit3 set, bit2 = player, bits[1:0] = heading.
    // Fire keys are 4'b001x with bit0 = player.
    typedef enum logic [3:0] {
        K_NONE    = 4'h0,
        K_PAUSE   = 4'h1,
        K_P1_FIRE = 4'h2,
        K_P2_FIRE = 4'h3,
        K_P1_UP   = 4'h8,
        K_P1_DN   = 4'h9,
        K_P1_LT   = 4'hA,
        K_P1_RT   = 4'hB,
        K_P2_UP   = 4'hC,
        K_P2_DN   = 4'hD,
        K_P2_LT   = 4'hE,
        K_P2_RT   = 4'hF
    } key_e;

    typedef enum logic {S_RUN = 1'b0, S_PAUSE = 1'b1} state_e;

    localparam logic [31:0] MV_RELOAD = 32'(MOVE_DIV - 1);
    localparam logic [31:0] CD_LOAD   = 32'(FIRE_CD);

    function automatic key_e decode(input logic [7:0] a);
        case (a)
            8'h77:   decode = K_P1_UP;
            8'h73:   decode = K_P1_DN;
            8'h61:   decode = K_P1_LT;
            8'h64:   decode = K_P1_RT;
            8'h20:   decode = K_P1_FIRE;
            8'h69:   decode = K_P2_UP;
            8'h6B:   decode = K_P2_DN;
            8'h6A:   decode = K_P2_LT;
            8'h6C:   decode = K_P2_RT;
            8'h0D:   decode = K_P2_FIRE;
            8'h70:   decode = K_PAUSE;
            default: decode = K_NONE;
        endcase
    endfunction

    logic [8:0]  prev_q, prev_d;
    key_e        held_q, held_d;
    state_e      state_q, state_d;
    logic [1:0]  dir_q[2], dir_d[2];
    logic        move_q[2], move_d[2];
    logic        fire_q[2], fire_d[2];
    logic [31:0] mv_cnt_q[2], mv_cnt_d[2];
    logic [31:0] cd_cnt_q[2], cd_cnt_d[2];

    key_e key_now;
    logic key_event;
    logic press_ev;
    logic running;

    always_comb begin
        key_now   = decode(kb.ascii);
        key_event = ({kb.press, kb.ascii} != prev_q);
        press_ev  = key_event && kb.press && (key_now != K_NONE);
        running   = (state_q == S_RUN);
        prev_d    = {kb.press, kb.ascii};

        held_d = held_q;
        if (key_event) held_d = kb.press ? key_now : K_NONE;

        state_d = state_q;
        if (press_ev && key_now == K_PAUSE) state_d = running ? S_PAUSE : S_RUN;

        for (int p = 0; p < 2; p++) begin
            dir_d[p]    = dir_q[p];
            move_d[p]   = 1'b0;
            fire_d[p]   = 1'b0;
            mv_cnt_d[p] = mv_cnt_q[p];
            cd_cnt_d[p] = cd_cnt_q[p];

            // A fresh press restarts the repeat interval; a steady hold counts it down.
            if (press_ev && key_now[3] && key_now[2] == 1'(p)) begin
                dir_d[p]    = key_now[1:0];
                mv_cnt_d[p] = MV_RELOAD;
                move_d[p]   = running;
            end else if (!key_event && running && held_q[3] && held_q[2] == 1'(p)) begin
                if (mv_cnt_q[p] == 32'd0) begin
                    move_d[p]   = 1'b1;
                    mv_cnt_d[p] = MV_RELOAD;
                end else begin
                    mv_cnt_d[p] = mv_cnt_q[p] - 32'd1;
                end
            end
            if (state_q == S_PAUSE && state_d == S_RUN) mv_cnt_d[p] = MV_RELOAD;

            if (running && cd_cnt_q[p] != 32'd0) cd_cnt_d[p] = cd_cnt_q[p] - 32'd1;
            if (press_ev && key_now[3:1] == 3'b001 && key_now[0] == 1'(p)
                && running && cd_cnt_q[p] == 32'd0) begin
                fire_d[p]   = 1'b1;
                cd_cnt_d[p] = CD_LOAD;
            end
`ifdef TANK_AUTOFIRE_EN
            else if (!key_event && held_q[3:1] == 3'b001 && held_q[0] == 1'(p)
                     && running && cd_cnt_q[p] == 32'd0) begin
                fire_d[p]   = 1'b1;
                cd_cnt_d[p] = CD_LOAD;
            end
`endif
        end
    end

    always_ff @(posedge clk_100mhz) begin
        if (rst) begin
            prev_q  <= '0;
            held_q  <= K_NONE;
            state_q <= S_RUN;
            for (int p = 0; p < 2; p++) begin
                dir_q[p]    <= 2'b00;
                move_q[p]   <= 1'b0;
                fire_q[p]   <= 1'b0;
                mv_cnt_q[p] <= '0;
                cd_cnt_q[p] <= '0;
            end
        end else begin
            prev_q  <= prev_d;
            held_q  <= held_d;
            state_q <= state_d;
            for (int p = 0; p < 2; p++) begin
                dir_q[p]    <= dir_d[p];
                move_q[p]   <= move_d[p];
                fire_q[p]   <= fire_d[p];
                mv_cnt_q[p] <= mv_cnt_d[p];
                cd_cnt_q[p] <= cd_cnt_d[p];
            end
        end
    end

    assign kb.p1_dir  = dir_q[0];
    assign kb.p1_move = move_q[0];
    assign kb.p1_fire = fire_q[0];
    assign kb.p2_dir  = dir_q[1];
    assign kb.p2_move = move_q[1];
    assign kb.p2_fire = fire_q[1];
    assign kb.paused  = (state_q == S_PAUSE);
endmodule

// File: tb/tb_tank_key_sched.sv
// tb/tb_tank_key_sched.sv - directed vector bench for tank_key_sched (MOVE_DIV=4, FIRE_CD=10)
module tb_tank_key_sched;
`ifdef TANK_AUTOFIRE_EN
    localparam bit AF = 1'b1;
`else
    localparam bit AF = 1'b0;
`endif

    typedef struct {
        logic       pr;
        logic [7:0] a;
        logic [8:0] exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    vec_t tbl[$];

    tank_key_sched_if kb();

    tank_key_sched #(.MOVE_DIV(4), .FIRE_CD(10)) dut (
        .clk_100mhz (clk),
        .rst        (rst),
        .kb         (kb)
    );

    always #5 clk = ~clk;

    // Packed output order: {p1_dir, p1_move, p1_fire, p2_dir, p2_move, p2_fire, paused}
    function automatic logic [8:0] o(input logic [1:0] d1, input logic m1, input logic f1,
                                     input logic [1:0] d2, input logic m2, input logic f2,
                                     input logic pz);
        return {d1, m1, f1, d2, m2, f2, pz};
    endfunction

    function automatic logic [8:0] outv();
        return {kb.p1_dir, kb.p1_move, kb.p1_fire, kb.p2_dir, kb.p2_move, kb.p2_fire, kb.paused};
    endfunction

    task automatic check(input string nm, input logic [8:0] act, input logic [8:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b want %b", nm, act, exp);
        end
    endtask

    task automatic cyc(input logic pr, input logic [7:0] a);
        kb.press = pr;
        kb.ascii = a;
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic pr, input logic [7:0] a, input logic [8:0] exp);
        tbl.push_back('{pr, a, exp});
    endtask

    initial begin
        int moves;
        rst = 1'b1;
        kb.press = 1'b0;
        kb.ascii = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        check("reset", outv(), o(2'b00, 0, 0, 2'b00, 0, 0, 0));
        rst = 1'b0;

        // hold w: pulses every 4 cycles
        add(1, 8'h77, o(2'b00, 1, 0, 2'b00, 0, 0, 0));
        for (int k = 1; k < 12; k++) add(1, 8'h77, o(2'b00, (k % 4 == 0), 0, 2'b00, 0, 0, 0));
        add(0, 8'h00, o(2'b00, 0, 0, 2'b00, 0, 0, 0));
        // fire, re-press inside cooldown, re-press after cooldown
        add(1, 8'h20, o(2'b00, 0, 1, 2'b00, 0, 0, 0));
        for (int k = 1; k < 5; k++) add(0, 8'h00, o(2'b00, 0, 0, 2'b00, 0, 0, 0));
        add(1, 8'h20, o(2'b00, 0, 0, 2'b00, 0, 0, 0));
        for (int k = 6; k < 15; k++) add(0, 8'h00, o(2'b00, 0, 0, 2'b00, 0, 0, 0));
        add(1, 8'h20, o(2'b00, 0, 1, 2'b00, 0, 0, 0));
        add(0, 8'h00, o(2'b00, 0, 0, 2'b00, 0, 0, 0));
        // d then switch to l without release
        add(1, 8'h64, o(2'b11, 1, 0, 2'b00, 0, 0, 0));
        add(1, 8'h64, o(2'b11, 0, 0, 2'b00, 0, 0, 0));
        add(1, 8'h6C, o(2'b11, 0, 0, 2'b11, 1, 0, 0));
        for (int k = 1; k < 5; k++) add(1, 8'h6C, o(2'b11, 0, 0, 2'b11, (k == 4), 0, 0));
        add(0, 8'h00, o(2'b11, 0, 0, 2'b11, 0, 0, 0));
        add(1, 8'h0D, o(2'b11, 0, 0, 2'b11, 0, 1, 0));
        add(0, 8'h00, o(2'b11, 0, 0, 2'b11, 0, 0, 0));
        // unmapped code: standalone, and replacing a held direction
        for (int k = 0; k < 3; k++) add(1, 8'h7A, o(2'b11, 0, 0, 2'b11, 0, 0, 0));
        add(0, 8'h00, o(2'b11, 0, 0, 2'b11, 0, 0, 0));
        add(1, 8'h64, o(2'b11, 1, 0, 2'b11, 0, 0, 0));
        for (int k = 0; k < 5; k++) add(1, 8'h7A, o(2'b11, 0, 0, 2'b11, 0, 0, 0));
        add(0, 8'h00, o(2'b11, 0, 0, 2'b11, 0, 0, 0));

        for (int i = 0; i < tbl.size(); i++) begin
            cyc(tbl[i].pr, tbl[i].a);
            check($sformatf("row%0d", i), outv(), tbl[i].exp);
        end

        // reset while a is held: fresh press after deassert
        cyc(1, 8'h61);
        check("t5_press", outv(), o(2'b10, 1, 0, 2'b11, 0, 0, 0));
        rst = 1'b1;
        cyc(1, 8'h61);
        check("t5_rst", outv(), o(2'b00, 0, 0, 2'b00, 0, 0, 0));
        rst = 1'b0;
        cyc(1, 8'h61);
        check("t5_fresh", outv(), o(2'b10, 1, 0, 2'b00, 0, 0, 0));
        cyc(1, 8'h61);
        check("t5_hold", outv(), o(2'b10, 0, 0, 2'b00, 0, 0, 0));

        // pause: dir tracks, pulses and cooldown freeze
        cyc(1, 8'h20);
        check("t4_fire_pre", outv(), o(2'b10, 0, 1, 2'b00, 0, 0, 0));
        cyc(0, 8'h00);
        cyc(1, 8'h70);
        check("t4_pause_on", outv(), o(2'b10, 0, 0, 2'b00, 0, 0, 1));
        cyc(0, 8'h00);
        cyc(1, 8'h73);
        check("t4_dir_paused", outv(), o(2'b01, 0, 0, 2'b00, 0, 0, 1));
        moves = 0;
        for (int k = 0; k < 20; k++) begin
            cyc(1, 8'h73);
            moves += int'(kb.p1_move);
        end
        check("t4_no_move_paused", 9'(moves), 9'd0);
        cyc(0, 8'h00);
        cyc(1, 8'h20);
        check("t4_fire_paused", outv(), o(2'b01, 0, 0, 2'b00, 0, 0, 1));
        cyc(0, 8'h00);
        cyc(1, 8'h70);
        check("t4_pause_off", outv(), o(2'b01, 0, 0, 2'b00, 0, 0, 0));
        cyc(0, 8'h00);
        cyc(1, 8'h20);
        check("t4_cd_frozen", outv(), o(2'b01, 0, 0, 2'b00, 0, 0, 0));
        cyc(0, 8'h00);
        cyc(1, 8'h73);
        check("t4_move_resume", outv(), o(2'b01, 1, 0, 2'b00, 0, 0, 0));
        for (int k = 1; k < 5; k++) begin
            cyc(1, 8'h73);
            check($sformatf("t4_repeat%0d", k), outv(), o(2'b01, (k == 4), 0, 2'b00, 0, 0, 0));
        end

        // continuous fire hold: autofire every 11 cycles only when enabled
        repeat (12) cyc(0, 8'h00);
        for (int k = 0; k < 23; k++) begin
            cyc(1, 8'h20);
            check($sformatf("t2_hold%0d", k), outv(),
                  o(2'b01, 0, (k == 0) || (AF && (k == 11 || k == 22)), 2'b00, 0, 0, 0));
        end
        cyc(0, 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
